// File: rtl/morse_key_sequencer.sv
// Morse key sequencer: times debounced presses and gaps into dot/dash letters.
// Define STUCK_KEY_TIMEOUT_EN to abort a letter on an over-long press.
module morse_key_sequencer #(
    parameter int CW         = 12,
    parameter int DOT_MAX    = 3,
    parameter int LETTER_GAP = 5,
    parameter int WORD_GAP   = 12,
    parameter int STUCK_MAX  = 400
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       DPB,
    input  logic       SCEN,
    input  logic       TICK,
    input  logic       SYM_READY,
    output logic       SYM_VALID,
    output logic [4:0] SYM_CODE,
    output logic [2:0] SYM_LEN,
    output logic       SYM_OVF,
    output logic       WORD_END,
    output logic       KEY_ERR
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        GAP,
        EMIT,
`ifdef STUCK_KEY_TIMEOUT_EN
        WAIT_REL,
`endif
        WGAP
    } state_t;

    localparam logic [CW-1:0] CMAX = '1;

    state_t        state, nstate;
    logic [CW-1:0] count, ncount, cinc;
    logic [4:0]    code, ncode;
    logic [2:0]    len, nlen;
    logic          ovf, novf;
    logic          pend, npend;
    logic          dash;
    logic          key_err;

`ifndef STUCK_KEY_TIMEOUT_EN
    logic unused_stuck;
    assign unused_stuck = (STUCK_MAX > 0);
`endif

    // Time base advances only on TICK and never wraps.
    assign cinc = (TICK && count != CMAX) ? count + CW'(1) : count;
    assign dash = (count > CW'(DOT_MAX));

    always_comb begin
        nstate  = state;
        ncount  = cinc;
        ncode   = code;
        nlen    = len;
        novf    = ovf;
        npend   = 1'b0;
        key_err = 1'b0;
        unique case (state)
            IDLE: begin
                ncount = '0;
                if (SCEN) begin
                    nstate = PRESS;
                end
            end
            PRESS: begin
`ifdef STUCK_KEY_TIMEOUT_EN
                if (count >= CW'(STUCK_MAX)) begin
                    key_err = 1'b1;
                    ncode   = '0;
                    nlen    = '0;
                    novf    = 1'b0;
                    ncount  = '0;
                    nstate  = WAIT_REL;
                end else if (!DPB) begin
`else
                if (!DPB) begin
`endif
                    if (len < 3'd5) begin
                        ncode = code | (5'(dash) << len);
                        nlen  = len + 3'd1;
                    end else begin
                        novf = 1'b1;
                    end
                    ncount = '0;
                    nstate = GAP;
                end
            end
            GAP: begin
                if (SCEN) begin
                    ncount = '0;
                    nstate = PRESS;
                end else if (count >= CW'(LETTER_GAP)) begin
                    nstate = EMIT;
                end
            end
            EMIT: begin
                npend = pend | SCEN;
                if (SYM_READY) begin
                    ncode = '0;
                    nlen  = '0;
                    novf  = 1'b0;
                    npend = 1'b0;
                    // A press keyed during the stall restarts timing here.
                    if (pend || SCEN || DPB) begin
                        ncount = '0;
                        nstate = PRESS;
                    end else begin
                        nstate = WGAP;
                    end
                end
            end
            WGAP: begin
                if (SCEN) begin
                    ncount = '0;
                    nstate = PRESS;
                end else if (count >= CW'(WORD_GAP)) begin
                    ncount = '0;
                    nstate = IDLE;
                end
            end
`ifdef STUCK_KEY_TIMEOUT_EN
            WAIT_REL: begin
                ncount = '0;
                if (!DPB) begin
                    nstate = IDLE;
                end
            end
`endif
            default: begin
                ncount = '0;
                nstate = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
            count <= '0;
            code  <= '0;
            len   <= '0;
            ovf   <= 1'b0;
            pend  <= 1'b0;
        end else begin
            state <= nstate;
            count <= ncount;
            code  <= ncode;
            len   <= nlen;
            ovf   <= novf;
            pend  <= npend;
        end
    end

    assign SYM_VALID = (state == EMIT);
    assign SYM_CODE  = code;
    assign SYM_LEN   = len;
    assign SYM_OVF   = ovf;
    assign WORD_END  = (state == WGAP) && (count >= CW'(WORD_GAP));
    assign KEY_ERR   = key_err;

endmodule
